// File: rtl/rb_param.sv
// ---------------------------------------------------------------------------
// rb_param : parametrised register bank, one write port, NUM_RD read ports,
//            with a sequenced bulk-clear engine.
//
// Parameters
//   DATA_W  : register width in bits
//   ADDR_W  : register-select width, DEPTH = 2**ADDR_W entries
//   NUM_RD  : number of independent combinational read ports
//   ZERO_R0 : 1 = register 0 reads as 0 and writes to it are discarded
//
// Ports
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   wr_en/addr/data  : single write port (writeback stage)
//   rd_addr, rd_data : packed read selects / data, port k at [k*W +: W]
//   clr_req          : start a bulk clear (sampled only while idle)
//   clr_busy         : clear sequence in progress, writes are rejected
//   clr_done         : one-cycle pulse after the last entry is cleared
//   wr_drop          : registered pulse, a write was rejected during clear
//
// Optional feature (macro RB_WRITE_BYPASS_EN):
//   defined   : an accepted write is forwarded to matching read ports in the
//               same cycle, and the entry being cleared reads as 0
//   undefined : reads return registered array contents only
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal operation, waits for clr_req
// CLEAR | wipes entry[cnt] each cycle, DEPTH cycles, writes rejected
// DONE  | one-cycle clr_done pulse, writes accepted, clr_req ignored
// ---------------------------------------------------------------------------
module rb_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    // DEPTH-1 expressed at counter width; the sequence ends on this value
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok;
    logic                r0_hit;

    assign r0_hit = (ZERO_R0 != 0) && (wr_addr == '0);
    assign wr_ok  = wr_en && (state != S_CLEAR) && !r0_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                clr_busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                clr_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (state == S_CLEAR);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] sel;
            logic [DATA_W-1:0] word;
            sel  = rd_addr[k*ADDR_W +: ADDR_W];
            word = mem[sel];
`ifdef RB_WRITE_BYPASS_EN
            if ((state == S_CLEAR) && (sel == cnt)) begin
                word = '0;
            end
            if (wr_ok && (sel == wr_addr)) begin
                word = wr_data;
            end
`endif
            // hardwired zero wins over any forwarding
            if ((ZERO_R0 != 0) && (sel == '0)) begin
                word = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = word;
        end
    end

endmodule

// File: tb/tb_rb_param.sv
// ---------------------------------------------------------------------------
// tb_rb_param : scoreboard bench for rb_param. Two instances share one
// write/clear stimulus stream: dut0 uses defaults (ZERO_R0=0, NUM_RD=2),
// dut1 uses ZERO_R0=1, NUM_RD=3. The driver computes each cycle's expected
// outputs from a behavioural model and queues them; a monitor on the falling
// edge pops and compares.
// ---------------------------------------------------------------------------
module tb_rb_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clr_req;
    logic [3:0]  ra0, ra1, ra2;
    logic [7:0]  rd_addr0;
    logic [11:0] rd_addr1;
    logic [31:0] rd_data0;
    logic [47:0] rd_data1;
    logic        busy0, done0, drop0;
    logic        busy1, done1, drop1;

    always #5 clk = ~clk;

    assign rd_addr0 = {ra1, ra0};
    assign rd_addr1 = {ra2, ra1, ra0};

    rb_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_R0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0), .wr_drop(drop0)
    );

    rb_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .ZERO_R0(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1), .wr_drop(drop1)
    );

    typedef struct packed {
        logic [31:0] d0;
        logic [47:0] d1;
        logic        busy;
        logic        done;
        logic        drop;
    } exp_t;

    exp_t q[$];
    int   ntests = 0;
    int   nfail  = 0;

    // reference model: plain arrays plus "cycles of clearing left"
    logic [15:0] m0 [16];
    logic [15:0] m1 [16];
    int          busy_left;
    bit          done_now;
    bit          drop_q;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input bit zr, input logic [3:0] a,
                                           input logic we, input logic [3:0] wa,
                                           input logic [15:0] wd);
        if (zr && a == 4'd0) return 16'h0;
`ifdef RB_WRITE_BYPASS_EN
        if (we && busy_left == 0 && !(zr && wa == 4'd0) && a == wa) return wd;
        if (busy_left > 0 && int'(a) == 16 - busy_left) return 16'h0;
`endif
        return zr ? m1[a] : m0[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        busy_left = 0;
        done_now  = 0;
        drop_q    = 0;
    endtask

    task automatic cycle(input bit rst, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd, input logic cr,
                         input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        exp_t e;
        bit   busy;
        @(posedge clk);
        #1;
        rst_n   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        clr_req = cr;
        ra0 = a0;
        ra1 = a1;
        ra2 = a2;
        if (!rst) model_reset();
        e.d0   = {exp_rd(0, a1, we, wa, wd), exp_rd(0, a0, we, wa, wd)};
        e.d1   = {exp_rd(1, a2, we, wa, wd), exp_rd(1, a1, we, wa, wd), exp_rd(1, a0, we, wa, wd)};
        e.busy = busy_left > 0;
        e.done = done_now;
        e.drop = drop_q;
        q.push_back(e);
        if (rst) begin
            busy   = busy_left > 0;
            drop_q = we && busy;
            if (!busy && we) begin
                m0[wa] = wd;
                if (wa != 4'd0) m1[wa] = wd;
            end
            if (busy) begin
                m0[16 - busy_left] = '0;
                m1[16 - busy_left] = '0;
                busy_left--;
                done_now = (busy_left == 0);
            end else if (done_now) begin
                done_now = 0;
            end else if (cr) begin
                busy_left = 16;
            end
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 4'd0, 16'h0, 0, 4'(i), 4'(15 - i), 4'(i));
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < 2; k++)
                chk($sformatf("dut0_rd_p%0d", k), 48'(rd_data0[k*16 +: 16]), 48'(e.d0[k*16 +: 16]));
            for (int k = 0; k < 3; k++)
                chk($sformatf("dut1_rd_p%0d", k), 48'(rd_data1[k*16 +: 16]), 48'(e.d1[k*16 +: 16]));
            chk("dut0_busy", 48'(busy0), 48'(e.busy));
            chk("dut0_done", 48'(done0), 48'(e.done));
            chk("dut0_drop", 48'(drop0), 48'(e.drop));
            chk("dut1_busy", 48'(busy1), 48'(e.busy));
            chk("dut1_done", 48'(done1), 48'(e.done));
            chk("dut1_drop", 48'(drop1), 48'(e.drop));
        end
    end

    initial begin
        rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; clr_req = 0;
        ra0 = 0; ra1 = 0; ra2 = 0;
        model_reset();

        // reset state
        cycle(0, 0, 4'd0, 16'h0, 0, 4'd0, 4'd1, 4'd2);
        cycle(0, 0, 4'd0, 16'h0, 0, 4'd3, 4'd15, 4'd0);

        // basic writes, readable next cycle
        cycle(1, 1, 4'd3,  16'hA5A5, 0, 4'd3, 4'd15, 4'd3);
        cycle(1, 1, 4'd15, 16'h1234, 0, 4'd3, 4'd15, 4'd15);
        cycle(1, 0, 4'd0,  16'h0,    0, 4'd3, 4'd15, 4'd3);
        read_all();

        // write with both ports watching the same entry
        cycle(1, 1, 4'd7, 16'hBEEF, 0, 4'd7, 4'd7, 4'd7);
        cycle(1, 0, 4'd0, 16'h0,    0, 4'd7, 4'd7, 4'd7);

        // fill, then clear with a rejected write and a second clr_req
        for (int i = 0; i < 16; i++)
            cycle(1, 1, 4'(i), 16'h1000 + 16'(i), 0, 4'(i), 4'd5, 4'd2);
        cycle(1, 0, 4'd0, 16'h0, 1, 4'd5, 4'd2, 4'd5);
        for (int j = 0; j < 20; j++)
            cycle(1, (j == 3), 4'd2, 16'hFFFF, (j == 6), 4'd5, 4'd2, 4'(j));
        read_all();

        // hardwired zero on dut1, write accepted by dut0
        cycle(1, 1, 4'd0, 16'h5555, 0, 4'd0, 4'd0, 4'd0);
        cycle(1, 0, 4'd0, 16'h0,    0, 4'd0, 4'd0, 4'd0);

        // reset in the middle of a clear
        for (int i = 0; i < 16; i++)
            cycle(1, 1, 4'(i), 16'h2000 + 16'(i), 0, 4'd9, 4'd12, 4'd9);
        cycle(1, 0, 4'd0, 16'h0, 1, 4'd9, 4'd12, 4'd3);
        for (int j = 0; j < 8; j++)
            cycle(1, 0, 4'd0, 16'h0, 0, 4'd9, 4'd12, 4'(j));
        cycle(0, 0, 4'd0, 16'h0, 0, 4'd9, 4'd12, 4'd8);
        cycle(0, 0, 4'd0, 16'h0, 0, 4'd9, 4'd12, 4'd10);
        read_all();
        cycle(1, 1, 4'd6, 16'h6666, 1, 4'd6, 4'd6, 4'd6);
        for (int j = 0; j < 20; j++)
            cycle(1, 0, 4'd0, 16'h0, 0, 4'd6, 4'(j), 4'd15);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic       we;
            logic [3:0] wa;
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            // a rejected write to r0 during clear is left out of the mix
            if (busy_left > 0 && wa == 4'd0) wa = 4'd1;
            cycle(1, we, wa, 16'($urandom), ($urandom_range(0, 19) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        cycle(1, 0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("sb_drain", 48'(q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
